// File: rtl/axi_bram_arb_pkg.sv
// Shared types and helpers for the two-master BRAM read arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axi_bram_arb_pkg;

    // Transaction phases of the shared BRAM read port
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [1:0] RRESP_OKAY = 2'b00;

    // Ceiling log2, used to size the byte-offset part of the AXI address
    function automatic int clogb2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (v > 0) begin
                r = r + 1;
                v = v >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a one-hot grant and a last-winner register.
// Latency: grant is combinational from req; last_grant updates on the advance edge.
// Backpressure: grant is only consumed when advance is high; otherwise it is re-evaluated each cycle.
module rr_arbiter2 (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       last_grant
);

    // A lone requester wins; on a tie the requester not served last wins
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Remember who won; reset to 1 so master 0 takes the first tie
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            last_grant <= 1'b1;
        end else if (advance && (grant != 2'b00)) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/axi_bram_read_arbiter.sv
// Shares one BRAM read port between two AXI4-Lite read-only slaves, one transaction at a time.
// Latency: AR handshake at edge E0, rvalid high after E2; 4 cycles per read with rready held high.
// Backpressure: rvalid/rdata hold until the owner's rready; nothing else is accepted meanwhile.
module axi_bram_read_arbiter
    import axi_bram_arb_pkg::*;
#(
    parameter int AXI_DATA_WIDTH  = 32,
    parameter int AXI_ADDR_WIDTH  = 16,
    parameter int BRAM_DATA_WIDTH = 32,
    parameter int BRAM_ADDR_WIDTH = 10
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0]  s0_axi_araddr,
    input  logic                       s0_axi_arvalid,
    output logic                       s0_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0]  s0_axi_rdata,
    output logic [1:0]                 s0_axi_rresp,
    output logic                       s0_axi_rvalid,
    input  logic                       s0_axi_rready,
    input  logic [AXI_ADDR_WIDTH-1:0]  s1_axi_araddr,
    input  logic                       s1_axi_arvalid,
    output logic                       s1_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0]  s1_axi_rdata,
    output logic [1:0]                 s1_axi_rresp,
    output logic                       s1_axi_rvalid,
    input  logic                       s1_axi_rready,
    output logic                       bram_porta_clk,
    output logic                       bram_porta_rst,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_porta_addr,
    input  logic [BRAM_DATA_WIDTH-1:0] bram_porta_rddata
);

    localparam int ADDR_LSB = clogb2(AXI_DATA_WIDTH / 8);

    state_t                     state_q;
    state_t                     state_d;
    logic [1:0]                 req;
    logic [1:0]                 grant;
    logic                       advance;
    logic                       owner;
    logic                       owner_rready;
    logic [BRAM_ADDR_WIDTH-1:0] addr_q;
    logic [AXI_DATA_WIDTH-1:0]  rdata_q;
    logic                       unused_araddr_bits;

    assign req     = {s1_axi_arvalid, s0_axi_arvalid};
    assign advance = (state_q == IDLE) && (req != 2'b00);

    // last_grant is written at the very edge the owner is chosen, so it doubles as the owner id
    rr_arbiter2 u_arb (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .req        (req),
        .advance    (advance),
        .grant      (grant),
        .last_grant (owner)
    );

    assign owner_rready = owner ? s1_axi_rready : s0_axi_rready;

    // Fixed four-phase sequence; only the response phase waits on the master
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req != 2'b00) state_d = ADDR;
            ADDR:    state_d = DATA;
            DATA:    state_d = RESP;
            RESP:    if (owner_rready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any in-flight read without a response
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the winner's word address at the AR handshake and the BRAM word in DATA
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            if (advance) begin
                addr_q <= grant[1] ? s1_axi_araddr[ADDR_LSB +: BRAM_ADDR_WIDTH]
                                   : s0_axi_araddr[ADDR_LSB +: BRAM_ADDR_WIDTH];
            end
            if (state_q == DATA) begin
                rdata_q <= bram_porta_rddata;
            end
        end
    end

    // Byte-offset and above-depth address bits are deliberately ignored (addresses wrap)
    assign unused_araddr_bits = ^{s0_axi_araddr, s1_axi_araddr};

    assign s0_axi_arready = (state_q == IDLE) && grant[0];
    assign s1_axi_arready = (state_q == IDLE) && grant[1];

    assign s0_axi_rvalid  = (state_q == RESP) && !owner;
    assign s1_axi_rvalid  = (state_q == RESP) && owner;
    assign s0_axi_rdata   = rdata_q;
    assign s1_axi_rdata   = rdata_q;
    assign s0_axi_rresp   = RRESP_OKAY;
    assign s1_axi_rresp   = RRESP_OKAY;

    assign bram_porta_clk  = aclk;
    assign bram_porta_rst  = ~aresetn;
    assign bram_porta_addr = addr_q;

endmodule

// File: doc/axi_bram_read_arbiter.md
# axi_bram_read_arbiter

Two-port read arbiter sharing one BRAM read port (port A, 1-cycle read latency) between two AXI4-Lite read-only masters, e.g. the PS GP port and a DMA/readout engine. Each master sees a plain AXI4-Lite read slave. A round-robin grant selects one transaction at a time, drives the BRAM address and captures the read word. The captured word is returned to the granted master with rresp OKAY.

## Interface
Parameters:
- AXI_DATA_WIDTH, 32, AXI data width; must equal BRAM_DATA_WIDTH.
- AXI_ADDR_WIDTH, 16, AXI byte-address width.
- BRAM_DATA_WIDTH, 32, BRAM word width.
- BRAM_ADDR_WIDTH, 10, BRAM word-address width.

Ports:
- aclk  in  1  clock. Reset is aresetn, synchronous, active-low; clock aclk.
- aresetn  in  1  synchronous active-low reset.
- s0_axi_araddr  in  AXI_ADDR_WIDTH  master 0 read address.
- s0_axi_arvalid  in  1  master 0 address valid.
- s0_axi_arready  out  1  master 0 address ready.
- s0_axi_rdata  out  AXI_DATA_WIDTH  master 0 read data.
- s0_axi_rresp  out  2  master 0 response; constant 2'd0.
- s0_axi_rvalid  out  1  master 0 data valid.
- s0_axi_rready  in  1  master 0 data ready.
- s1_axi_*  same set as s0, for master 1.
- bram_porta_clk  out  1  equals aclk.
- bram_porta_rst  out  1  equals ~aresetn.
- bram_porta_addr  out  BRAM_ADDR_WIDTH  word address: araddr[ADDR_LSB+BRAM_ADDR_WIDTH-1:ADDR_LSB], ADDR_LSB = clog2(AXI_DATA_WIDTH/8).
- bram_porta_rddata  in  BRAM_DATA_WIDTH  BRAM output, valid one cycle after the address is sampled.

## Operation
- FSM states:
  - IDLE: accepting.
  - ADDR: address held at BRAM.
  - DATA: BRAM word captured.
  - RESP: rvalid high to the owner.
- IDLE → ADDR:
  - Triggered when any arvalid is high.
  - Grant: if only one master is valid, it wins. If both are valid, the master not granted last wins.
  - At that edge: the winner's arready is high, araddr is registered, owner is recorded, last_grant is updated.
- ADDR → DATA: unconditional. BRAM samples the registered address at this edge.
- DATA → RESP: unconditional. bram_porta_rddata is captured into the rdata register at this edge.
- RESP → IDLE: when the owner's rready is high.
- rdata register is shared between both rdata ports. Only the owner's rvalid is asserted.
- arready_n = (state==IDLE) & arvalid_n & grant_n. arready may depend combinationally on arvalid; this is legal AXI. No other combinational path from inputs to outputs exists.
- The non-owner's arvalid is held pending. It is granted on the next IDLE cycle.
- bram_porta_addr is driven from the registered address at all times, so it is stable through ADDR and DATA.
- The block has no write channels. Address bits outside the slice are ignored, so addresses wrap modulo BRAM depth.

## Timing
- Reset values:
  - state IDLE.
  - last_grant = 1, so master 0 wins the first tie.
  - s0/s1 arready 0.
  - s0/s1 rvalid 0.
  - rdata 0.
  - address register 0.
- Reset mid-transaction: the in-flight read is dropped, rvalid deasserts on the next edge, and no response is issued.
- Latency: AR handshake at edge E0 → rvalid high after E2, i.e. the third cycle after the handshake. When rready is already high, one transaction completes every 4 cycles.
- rvalid and rdata are held stable until rready. An rready stall blocks the other master; this is intended, as there is no per-master buffering.
- Arbitration order while both masters continuously request: 0, 1, 0, 1, ...
- A new arvalid from the owner during RESP is not accepted until IDLE.

## Structure
- Package axi_bram_arb_pkg holds:
  - state enum {IDLE, ADDR, DATA, RESP}.
  - clogb2 function.
  - localparam for rresp OKAY.
- Sub-module rr_arbiter2: 2-way round-robin.
  - Inputs: req[1:0], advance, clock, reset.
  - Outputs: one-hot grant and the last_grant register.
  - Instantiated once.

## Test plan
- Single read, master 0: BRAM preloaded with mem[5]=0xA5A5_0005. s0 araddr=0x0014 → arready at E0, rvalid after E2, rdata=0xA5A5_0005, rresp=0, s1 rvalid stays 0.
- Simultaneous request after reset: s0→0x0000 and s1→0x0004 issued in the same cycle → s0 is served first, then s1 is accepted in the following IDLE. Data is mem[0] then mem[1].
- Continuous contention: both masters issue 8 back-to-back reads → grants alternate 0,1,...; every response is matched to the correct address; throughput is 4 cycles per read.
- rready stall: s1 holds rready=0 for 10 cycles → rvalid and rdata are held stable, s0 arready stays 0, and s0 is served immediately after the s1 handshake.
- Address wrap: araddr=0x1008 with BRAM_ADDR_WIDTH=10 → bram_porta_addr=2, data=mem[2].
- Reset mid-operation: aresetn low during DATA → the next cycle has all rvalid/arready 0 and state IDLE. The first post-reset tie is granted to s0.
